multicycle_ctrl: RTL

//  FSM controller sequencing a shared-memory multicycle RV32I datapath (PC, IR/OldPC, regfile, ALU, ALUOut, one memory port).

---
 rtl/riscv_mc_pkg.sv | 31 +++
 rtl/mc_perf_counters.sv | 21 ++
 rtl/multicycle_ctrl.sv | 139 +++++++++++++
 3 files changed

// File: rtl/riscv_mc_pkg.sv
// riscv_mc_pkg: states, opcodes and datapath select encodings for the multicycle RV32I controller
package riscv_mc_pkg;
  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_EXEC, S_ALU_WB, S_MEM_ADDR,
    S_MEM_RD, S_MEM_WB, S_MEM_WR, S_BRANCH, S_TRAP
  } state_t;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_R   = 2'b10;
  localparam logic [1:0] ALU_I   = 2'b11;
  localparam logic [1:0] SRC_A_PC    = 2'b00;
  localparam logic [1:0] SRC_A_OLDPC = 2'b01;
  localparam logic [1:0] SRC_A_RS1   = 2'b10;
  localparam logic [1:0] SRC_B_RS2  = 2'b00;
  localparam logic [1:0] SRC_B_FOUR = 2'b01;
  localparam logic [1:0] SRC_B_IMM  = 2'b10;
  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;
  function automatic state_t decode_next(input logic [6:0] op);
    if (op == OP_R || op == OP_I) return S_EXEC;
    if (op == OP_LOAD || op == OP_STORE) return S_MEM_ADDR;
    if (op == OP_BRANCH) return S_BRANCH;
    return S_TRAP;
  endfunction
endpackage

// File: rtl/mc_perf_counters.sv
// mc_perf_counters: free-running cycle and retired-instruction counters, wrapping at 2^CNT_W
module mc_perf_counters #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             retire,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt
);
  // count every clock out of reset, and every retiring micro-step
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycle_cnt   <= '0;
      instret_cnt <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + 1'b1;
      if (retire) instret_cnt <= instret_cnt + 1'b1;
    end
  end
endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: FSM sequencing a shared-memory multicycle RV32I datapath; perf counters under MC_CTRL_PERF_EN
module multicycle_ctrl
  import riscv_mc_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run_en,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             iord,
  output logic             ir_write,
  output logic             pc_write,
  output logic             pc_src,
  output logic             reg_write,
  output logic             mem_to_reg,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic             trap,
  output logic [1:0]       trap_cause,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt
);
  localparam int WW = MEM_TIMEOUT > 0 ? $clog2(MEM_TIMEOUT + 1) : 1;
  state_t state, next;
  logic busy, stall, tmo;
  logic [WW-1:0] wait_cnt;
  assign trap = state == S_TRAP;
  // next-state and datapath controls; a fetch already issued stays requested until it completes
  always_comb begin
    next = state;
    mem_req = 1'b0;
    mem_we = 1'b0;
    iord = 1'b0;
    ir_write = 1'b0;
    pc_write = 1'b0;
    pc_src = 1'b0;
    reg_write = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a = SRC_A_PC;
    alu_src_b = SRC_B_RS2;
    alu_op = ALU_ADD;
    case (state)
      S_FETCH: begin
        mem_req = (run_en | busy) & ~reset;
        alu_src_b = mem_req ? SRC_B_FOUR : SRC_B_RS2;
        ir_write = mem_req & mem_ready;
        pc_write = mem_req & mem_ready;
        if (mem_req & mem_ready) next = S_DECODE;
      end
      S_DECODE: begin
        alu_src_a = SRC_A_OLDPC;
        alu_src_b = SRC_B_IMM;
        next = decode_next(opcode);
      end
      S_EXEC: begin
        alu_src_a = SRC_A_RS1;
        alu_src_b = opcode == OP_R ? SRC_B_RS2 : SRC_B_IMM;
        alu_op = opcode == OP_R ? ALU_R : ALU_I;
        next = S_ALU_WB;
      end
      S_ALU_WB: begin
        reg_write = 1'b1;
        next = S_FETCH;
      end
      S_MEM_ADDR: begin
        alu_src_a = SRC_A_RS1;
        alu_src_b = SRC_B_IMM;
        if (opcode == OP_LOAD) next = S_MEM_RD;
        else next = S_MEM_WR;
      end
      S_MEM_RD: begin
        mem_req = 1'b1;
        iord = 1'b1;
        if (mem_ready) next = S_MEM_WB;
      end
      S_MEM_WB: begin
        reg_write = 1'b1;
        mem_to_reg = 1'b1;
        next = S_FETCH;
      end
      S_MEM_WR: begin
        mem_req = 1'b1;
        mem_we = 1'b1;
        iord = 1'b1;
        if (mem_ready) next = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a = SRC_A_RS1;
        alu_op = ALU_SUB;
        pc_src = 1'b1;
        pc_write = (funct3 == 3'b000 & zero) | (funct3 == 3'b001 & ~zero);
        next = S_FETCH;
      end
      S_TRAP: next = S_TRAP;
      default: next = S_FETCH;
    endcase
    stall = mem_req & ~mem_ready;
    tmo = (MEM_TIMEOUT != 0) && stall && (wait_cnt == WW'(MEM_TIMEOUT - 1));
    if (tmo) next = S_TRAP;
  end
  // state, pending-fetch flag, per-access wait counter and first fault cause
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_FETCH;
      busy       <= 1'b0;
      wait_cnt   <= '0;
      trap_cause <= CAUSE_NONE;
    end else begin
      state    <= next;
      busy     <= stall;
      wait_cnt <= stall ? wait_cnt + 1'b1 : '0;
      if (next == S_TRAP && state != S_TRAP && trap_cause == CAUSE_NONE)
        trap_cause <= tmo ? CAUSE_TIMEOUT : CAUSE_ILLEGAL;
    end
  end
`ifdef MC_CTRL_PERF_EN
  logic retire;
  assign retire = state == S_ALU_WB || state == S_MEM_WB || state == S_BRANCH ||
                  (state == S_MEM_WR && mem_ready);
  mc_perf_counters #(.CNT_W(CNT_W)) u_perf (
    .clk(clk),
    .reset(reset),
    .retire(retire),
    .cycle_cnt(cycle_cnt),
    .instret_cnt(instret_cnt)
  );
`else
  assign cycle_cnt = '0;
  assign instret_cnt = '0;
`endif
endmodule
